mdu_sequencer: RTL and testbench

- Iterative multiply/divide unit (MDU) for the processor. Executes MULT, MULTU, DIV and DIVU over 32 cycles and owns the HI/LO register pair.
- Sits beside the main ALU. The main control unit decodes the mult/div/mthi/mtlo funct codes and issues `start` or `wr_hi`/`wr_lo`. `busy` stalls the PC until the unit finishes.

---
 rtl/mdu_sequencer_pkg.sv | 32 +++
 rtl/mdu_sequencer_if.sv | 27 ++
 rtl/mdu_sequencer_step.sv | 29 ++
 rtl/mdu_sequencer.sv | 136 +++++++++++++
 tb/tb_mdu_sequencer.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/mdu_sequencer_pkg.sv
// rtl/mdu_sequencer_pkg.sv - shared op codes, FSM states and decode constants for the MDU
package mdu_sequencer_pkg;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } mdu_state_e;

    // Funct field values the main decoder uses to steer an instruction here
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_MTHI  = 6'h11;
    localparam logic [5:0] FUNCT_MTLO  = 6'h13;

    function automatic logic is_mdu_funct(input logic [5:0] funct);
        return (funct == FUNCT_MULT) || (funct == FUNCT_MULTU) ||
               (funct == FUNCT_DIV)  || (funct == FUNCT_DIVU)  ||
               (funct == FUNCT_MTHI) || (funct == FUNCT_MTLO);
    endfunction

endpackage

// File: rtl/mdu_sequencer_if.sv
// rtl/mdu_sequencer_if.sv - control/result bundle between the decoder and the MDU
interface mdu_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             wr_hi;
    logic             wr_lo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic             dz;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, wr_hi, wr_lo, wdata,
        input  busy, done, dz, hi, lo
    );

    modport slave (
        input  start, op, a, b, wr_hi, wr_lo, wdata,
        output busy, done, dz, hi, lo
    );
endinterface

// File: rtl/mdu_sequencer_step.sv
// rtl/mdu_sequencer_step.sv - one shift-add multiply or restoring-divide iteration
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             div_i,
    input  logic [WIDTH-1:0] hi_i,
    input  logic [WIDTH-1:0] lo_i,
    input  logic [WIDTH-1:0] opnd_i,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;

    always_comb begin
        sum    = lo_i[0] ? ({1'b0, hi_i} + {1'b0, opnd_i}) : {1'b0, hi_i};
        rem_sh = {hi_i, lo_i[WIDTH-1]};
        // Remainder stays below the divisor, so bit WIDTH of trial is a clean borrow
        trial  = rem_sh - {1'b0, opnd_i};
        if (div_i) begin
            hi_o = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
            lo_o = {lo_i[WIDTH-2:0], ~trial[WIDTH]};
        end else begin
            hi_o = sum[WIDTH:1];
            lo_o = {sum[0], lo_i[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/mdu_sequencer.sv
// rtl/mdu_sequencer.sv - iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    mdu_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    mdu_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] wh_q, wh_d, wl_q, wl_d, opnd_q, opnd_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic             is_div_q, is_div_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0]   step_hi, step_lo;
    logic [WIDTH-1:0]   a_abs, b_abs;
    logic               signed_op;
    logic [2*WIDTH-1:0] prod;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .div_i  (is_div_q),
        .hi_i   (wh_q),
        .lo_i   (wl_q),
        .opnd_i (opnd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wh_d      = wh_q;
        wl_d      = wl_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        is_div_d  = is_div_q;
        neg_q_d   = neg_q_q;
        neg_r_d   = neg_r_q;
        dz_d      = dz_q;
        signed_op = ~bus.op[0];
        a_abs     = (signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        b_abs     = (signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        prod      = neg_q_q ? -{wh_q, wl_q} : {wh_q, wl_q};

        case (state_q)
            S_IDLE: begin
                if (bus.wr_hi) hi_d = bus.wdata;
                if (bus.wr_lo) lo_d = bus.wdata;
                if (bus.start) begin
                    is_div_d = bus.op[1];
                    neg_q_d  = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                    neg_r_d  = signed_op & bus.a[WIDTH-1];
                    dz_d     = 1'b0;
                    cnt_d    = CNT_LAST;
                    wh_d     = '0;
                    // Divide shifts the dividend out of lo; multiply consumes the multiplier from lo
                    wl_d     = bus.op[1] ? a_abs : b_abs;
                    opnd_d   = bus.op[1] ? b_abs : a_abs;
                    state_d  = S_RUN;
                    if (bus.op[1] && (bus.b == '0)) begin
                        dz_d    = 1'b1;
                        hi_d    = bus.a;
                        lo_d    = '1;
                        state_d = S_DONE;
                    end
                end
            end
            S_RUN: begin
                wh_d  = step_hi;
                wl_d  = step_lo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) state_d = S_FIX;
            end
            S_FIX: begin
                if (is_div_q) begin
                    lo_d = neg_q_q ? -wl_q : wl_q;
                    hi_d = neg_r_q ? -wh_q : wh_q;
                end else begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                state_d = S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            wh_q     <= '0;
            wl_q     <= '0;
            opnd_q   <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wh_q     <= wh_d;
            wl_q     <= wl_d;
            opnd_q   <= opnd_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            is_div_q <= is_div_d;
            neg_q_q  <= neg_q_d;
            neg_r_q  <= neg_r_d;
            dz_q     <= dz_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = (state_q == S_DONE);
    assign bus.dz   = dz_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// tb/tb_mdu_sequencer.sv - scoreboard bench for mdu_sequencer against a 64-bit arithmetic model
module tb_mdu_sequencer;
    import mdu_sequencer_pkg::*;

    typedef struct {
        int          cyc;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mdu_sequencer_if #(.WIDTH(32)) bus ();
    mdu_sequencer #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          last_done = -1;
    int          prev_done = -1;
    exp_t        sb_q[$];
    logic [31:0] last_lo = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa, sbv, p;
        logic [63:0] u;
        sa  = longint'($signed(a));
        sbv = longint'($signed(b));
        z   = 1'b0;
        case (op)
            2'd0: begin p = sa * sbv; h = p[63:32]; l = p[31:0]; end
            2'd1: begin u = {32'd0, a} * {32'd0, b}; h = u[63:32]; l = u[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    z = 1'b1; h = a; l = 32'hFFFF_FFFF;
                end else if (op == 2'd2) begin
                    p = sa / sbv; l = p[31:0];
                    p = sa % sbv; h = p[31:0];
                end else begin
                    l = a / b; h = a % b;
                end
            end
        endcase
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n && bus.done === 1'b1) begin
            prev_done = last_done;
            last_done = cyc;
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_done: done at cycle %0d with no operation pending", cyc);
            end else begin
                e = sb_q.pop_front();
                check("done_cycle", 64'(cyc), 64'(e.cyc));
                check("hi", {32'd0, bus.hi}, {32'd0, e.hi});
                check("lo", {32'd0, bus.lo}, {32'd0, e.lo});
                check("dz", {63'd0, bus.dz}, {63'd0, e.dz});
                check("busy_at_done", {63'd0, bus.busy}, 64'd1);
            end
        end
    end

    task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (bus.busy !== 1'b0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_tests++;
            n_fail++;
            $display("FAIL idle_timeout: busy stuck at %b", bus.busy);
        end
        bus.start = 1'b1;
        bus.op    = op;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        model(op, a, b, e.hi, e.lo, e.dz);
        e.cyc = (op[1] && b == 32'd0) ? cyc : cyc + 33;
        sb_q.push_back(e);
        last_lo = e.lo;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            @(negedge clk);
            t++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic write_hl(input logic whi, input logic wlo, input logic [31:0] d);
        @(negedge clk);
        bus.wr_hi = whi;
        bus.wr_lo = wlo;
        bus.wdata = d;
        @(posedge clk);
        #1;
        bus.wr_hi = 1'b0;
        bus.wr_lo = 1'b0;
    endtask

    initial begin
        logic [31:0] ra, rb, rd;
        logic [1:0]  rop;
        bus.start = 1'b0; bus.op = 2'd0; bus.a = '0; bus.b = '0;
        bus.wr_hi = 1'b0; bus.wr_lo = 1'b0; bus.wdata = '0;

        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, bus.busy}, 64'd0);
        check("rst_done", {63'd0, bus.done}, 64'd0);
        check("rst_dz",   {63'd0, bus.dz}, 64'd0);
        check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;

        do_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        check("busy_cycle1", {63'd0, bus.busy}, 64'd1);
        drain();
        do_op(2'd0, 32'hFFFF_FFF9, 32'd6);
        do_op(2'd2, 32'hFFFF_FFF9, 32'd2);
        do_op(2'd3, 32'd100, 32'd0);
        do_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        do_op(2'd2, 32'd7, 32'd0);
        drain();

        write_hl(1'b1, 1'b0, 32'h0000_1234);
        @(negedge clk);
        check("mthi_hi", {32'd0, bus.hi}, 64'h1234);
        check("mthi_lo_kept", {32'd0, bus.lo}, {32'd0, last_lo});
        rd = $urandom;
        write_hl(1'b0, 1'b1, rd);
        @(negedge clk);
        check("mtlo_lo", {32'd0, bus.lo}, {32'd0, rd});
        write_hl(1'b1, 1'b1, 32'hCAFE_F00D);
        @(negedge clk);
        check("mthilo_both", {bus.hi, bus.lo}, 64'hCAFE_F00D_CAFE_F00D);

        do_op(2'd0, 32'hFFFF_FFF9, 32'd6);
        repeat (5) @(negedge clk);
        bus.start = 1'b1; bus.op = 2'd3; bus.a = 32'd1; bus.b = 32'd0;
        bus.wr_lo = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.wr_lo = 1'b0;
        @(negedge clk);
        check("busy_ignore", {63'd0, bus.busy}, 64'd1);
        check("lo_ignore_wr", {32'd0, bus.lo}, 64'hCAFE_F00D);
        drain();
        check("no_extra_op", {63'd0, bus.busy}, 64'd0);

        do_op(2'd2, 32'd1000, 32'd7);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {63'd0, bus.busy}, 64'd0);
        check("abort_done", {63'd0, bus.done}, 64'd0);
        check("abort_hilo", {bus.hi, bus.lo}, 64'd0);
        sb_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        do_op(2'd1, 32'd3, 32'd5);
        drain();

        do_op(2'd0, 32'd12345, 32'hFFFF_0000);
        do_op(2'd3, 32'hFFFF_FFFF, 32'd3);
        drain();
        check("back_to_back", 64'(last_done - prev_done), 64'd35);

        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: ra = 32'h8000_0000;
                2: rb = 32'hFFFF_FFFF;
                3: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(rop, ra, rb);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
